multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Moore-style sequencing FSM for the multi-cycle processor datapath. Walks each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath control strobe: register-file write, memory read/write, IR/PC write, operand muxes, ALUOp and PCSource. Adds a memory-ready stall handshake, a halt state and an illegal-opcode trap. The processor top instantiates it in place of the combinational control unit.

## Interface
- No parameters; all encodings are fixed in `mc_pkg`.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous, active-low reset.
- `opcode` in 6: current `ins[31:26]`, valid from DECODE onward.
- `mem_ready` in 1: memory completes the access in this cycle. Tie to 1 for zero-wait memory.
- `RegDst`, `ALUSrcA`, `MemtoReg`, `RegWrite`, `MemRead`, `MemWrite`, `Branch`, `PCWrite`, `IRWrite`, `IorD` out 1: datapath strobes, same meaning as the existing control unit.
- `ALUOp` out 2: 00 add, 01 sub, 10 use funct.
- `ALUSrcB` out 2: 00 regB, 01 constant 4, 10 imm32, 11 branch displacement.
- `PCSource` out 2: 00 alu_result, 01 alu_reg, 10 jump target, 11 zero vector.
- `state` out 4: current state, for debug.
- `retire` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal` out 1: one-cycle pulse while in TRAP.
- `halted` out 1: level, high while in HALT.

## Operation
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000, HALT 111111. Every other opcode is illegal.
- Unlisted strobes are 0 in every state. Multi-bit fields default to 00.
- FETCH: MemRead=1, ALUSrcB=01, IRWrite=PCWrite=mem_ready. Leaves for DECODE when mem_ready=1; otherwise stays.
- DECODE: ALUSrcB=11. Dispatches on opcode:
  - LW/SW → MEMADR
  - R → REXEC
  - BEQ → BEQ
  - J → JMP
  - ADDI → ADDIEX
  - HALT → HALT
  - anything else → TRAP
- MEMADR: ALUSrcA=1, ALUSrcB=10. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: MemRead=1, IorD=1. Goes to MEMWB when mem_ready=1; otherwise stays.
- MEMWB: RegWrite=1, MemtoReg=1, retire=1. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. On mem_ready=1: retire=1, goes to FETCH. Otherwise stays.
- REXEC: ALUSrcA=1, ALUOp=10. Goes to RWB.
- RWB: RegDst=1, RegWrite=1, retire=1. Goes to FETCH.
- BEQ: ALUSrcA=1, ALUOp=01, Branch=1, PCSource=01, retire=1. Goes to FETCH.
- JMP: PCWrite=1, PCSource=10, retire=1. Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Goes to ADDIWB.
- ADDIWB: RegWrite=1, retire=1. Goes to ADDIWB→FETCH transition after one cycle.
- TRAP: PCWrite=1, PCSource=11, illegal=1. Goes to FETCH; the PC restarts at 0.
- HALT: all strobes 0, halted=1. Stays until reset.

## Timing
- State register updates on the rising edge of `clk`. Outputs decode combinationally from the state register and `mem_ready` only, never from `opcode` (DECODE transitions are the only place `opcode` is used).
- Reset: while rst_n=0, the next state is FETCH and every strobe, `retire`, `illegal` and `halted` is forced to 0. `state` reads FETCH from the first edge with rst_n=0. Reset mid-instruction or mid-stall abandons the instruction; no write strobe fires.
- The first cycle after rst_n rises is an unstalled-eligible FETCH.
- Latency with mem_ready=1: R 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4 cycles. Each stalled cycle adds one.
- `mem_ready` is sampled only in FETCH, MEMRD and MEMWR; it is ignored elsewhere.
- `mem_ready` high on the first cycle of a memory state completes that access in that cycle. Write strobes never repeat during a stall: IRWrite and PCWrite are gated by ready, and MemWrite is idempotent while held.

## Structure
- `mc_pkg` holds:
  - state enum, 4-bit: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, BEQ, JMP, ADDIEX, ADDIWB, TRAP, HALT
  - opcode constants
  - ALUOp, ALUSrcB and PCSource encodings
- One sub-module, `mc_ctrl_decode`: purely combinational state+mem_ready → strobes. `multicycle_ctrl` keeps the state register and next-state logic.

## Test plan
- Reset held 3 cycles mid-REXEC, then released → all strobes 0 during reset; FETCH with MemRead=1, ALUSrcB=01 on the first cycle after release.
- mem_ready=1; opcodes R, LW, SW, BEQ, J, ADDI in sequence → exact state sequences above, `retire` exactly once per instruction on cycles 4, 5, 4, 3, 3, 4.
- LW with mem_ready low 2 cycles in FETCH and 3 in MEMRD → 10 total cycles; IRWrite/PCWrite high only on the ready cycle; RegWrite once.
- SW with mem_ready low 1 cycle in MEMWR → MemWrite held 2 cycles, `retire` on the second only.
- Opcode 010101 → TRAP next cycle with PCWrite=1, PCSource=11, illegal=1; then FETCH.
- Opcode 111111 → HALT, halted=1 held for 20 cycles with all strobes 0; rst_n pulse → FETCH, halted=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle sequencing controller: states, opcodes,
// datapath select encodings and the strobe bundle driven by the decoder.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    REXEC,
    RWB,
    BEQ,
    JMP,
    ADDIEX,
    ADDIWB,
    TRAP,
    HALT
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BDISP = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUREG = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_ZERO   = 2'b11;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src_a;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       retire;
    logic       illegal;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: current state plus mem_ready to datapath strobes.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        // IR/PC only capture on the ready cycle so a stall never double-writes
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: ctrl.alu_src_b = SRCB_BDISP;
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.retire    = mem_ready;
      end
      REXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      RWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
      end
      BEQ: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.branch    = 1'b1;
        ctrl.pc_source = PCS_ALUREG;
        ctrl.retire    = 1'b1;
      end
      JMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
        ctrl.retire    = 1'b1;
      end
      ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ADDIWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
      end
      TRAP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_ZERO;
        ctrl.illegal   = 1'b1;
      end
      HALT: ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle processor sequencing FSM: state register, next-state logic and
// reset masking of the decoded strobes.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal,
  output logic       halted
);

  state_t state_q, state_d;
  logic   is_lw_q;
  ctrl_t  ctrl_dec, ctrl;

  // LW/SW choice is latched at dispatch so opcode is only consulted in DECODE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      is_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) is_lw_q <= (opcode == OP_LW);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = REXEC;
          OP_BEQ:       state_d = BEQ;
          OP_J:         state_d = JMP;
          OP_ADDI:      state_d = ADDIEX;
          OP_HALT:      state_d = HALT;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR: state_d = is_lw_q ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (mem_ready) state_d = FETCH;
      REXEC:  state_d = RWB;
      RWB:    state_d = FETCH;
      BEQ:    state_d = FETCH;
      JMP:    state_d = FETCH;
      ADDIEX: state_d = ADDIWB;
      ADDIWB: state_d = FETCH;
      TRAP:   state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_dec)
  );

  // Masking here keeps a reset asserted mid-instruction from firing any write
  assign ctrl = rst_n ? ctrl_dec : '0;

  assign RegDst   = ctrl.reg_dst;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegWrite = ctrl.reg_write;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign Branch   = ctrl.branch;
  assign PCWrite  = ctrl.pc_write;
  assign IRWrite  = ctrl.ir_write;
  assign IorD     = ctrl.i_or_d;
  assign ALUOp    = ctrl.alu_op;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign PCSource = ctrl.pc_source;
  assign retire   = ctrl.retire;
  assign illegal  = ctrl.illegal;
  assign halted   = ctrl.halted;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed cycle-by-cycle check of multicycle_ctrl state sequence and strobes.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       RegDst, ALUSrcA, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic       PCWrite, IRWrite, IorD, retire, illegal, halted;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic [3:0] state;
  logic [18:0] obs;

  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .IorD(IorD), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .state(state), .retire(retire), .illegal(illegal),
    .halted(halted)
  );

  assign obs = {RegDst, ALUSrcA, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
                PCWrite, IRWrite, IorD, ALUOp, ALUSrcB, PCSource,
                retire, illegal, halted};

  // {RegDst,ALUSrcA,MemtoReg,RegWrite,MemRead,MemWrite,Branch,PCWrite,IRWrite,IorD,
  //  ALUOp,ALUSrcB,PCSource,retire,illegal,halted}
  function automatic logic [18:0] mk(
    input logic rd, asa, m2r, rw, mr, mw, br, pcw, irw, iord,
    input logic [1:0] aop, srcb, pcs,
    input logic ret, ill, hlt);
    return {rd, asa, m2r, rw, mr, mw, br, pcw, irw, iord, aop, srcb, pcs, ret, ill, hlt};
  endfunction

  logic [18:0] E_ZERO, E_FETCH, E_FSTALL, E_DEC, E_MADR, E_MRD, E_MWB, E_MWR, E_MWRST;
  logic [18:0] E_REX, E_RWB, E_BEQ, E_JMP, E_AEX, E_AWB, E_TRAP, E_HALT;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at posedge+1: apply mem_ready, check the current cycle, advance one edge.
  task automatic cyc(input string tag, input logic mr, input state_t es, input logic [18:0] ev);
    mem_ready = mr;
    #1;
    chk({tag, ".state"}, {28'd0, state}, {28'd0, es});
    chk({tag, ".out"}, {13'd0, obs}, {13'd0, ev});
    @(posedge clk);
    #1;
  endtask

  initial begin
    E_ZERO   = '0;
    E_FETCH  = mk(0,0,0,0,1,0,0,1,1,0, 2'b00,2'b01,2'b00, 0,0,0);
    E_FSTALL = mk(0,0,0,0,1,0,0,0,0,0, 2'b00,2'b01,2'b00, 0,0,0);
    E_DEC    = mk(0,0,0,0,0,0,0,0,0,0, 2'b00,2'b11,2'b00, 0,0,0);
    E_MADR   = mk(0,1,0,0,0,0,0,0,0,0, 2'b00,2'b10,2'b00, 0,0,0);
    E_MRD    = mk(0,0,0,0,1,0,0,0,0,1, 2'b00,2'b00,2'b00, 0,0,0);
    E_MWB    = mk(0,0,1,1,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,0,0);
    E_MWR    = mk(0,0,0,0,0,1,0,0,0,1, 2'b00,2'b00,2'b00, 1,0,0);
    E_MWRST  = mk(0,0,0,0,0,1,0,0,0,1, 2'b00,2'b00,2'b00, 0,0,0);
    E_REX    = mk(0,1,0,0,0,0,0,0,0,0, 2'b10,2'b00,2'b00, 0,0,0);
    E_RWB    = mk(1,0,0,1,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,0,0);
    E_BEQ    = mk(0,1,0,0,0,0,1,0,0,0, 2'b01,2'b00,2'b01, 1,0,0);
    E_JMP    = mk(0,0,0,0,0,0,0,1,0,0, 2'b00,2'b00,2'b10, 1,0,0);
    E_AEX    = mk(0,1,0,0,0,0,0,0,0,0, 2'b00,2'b10,2'b00, 0,0,0);
    E_AWB    = mk(0,0,0,1,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,0,0);
    E_TRAP   = mk(0,0,0,0,0,0,0,1,0,0, 2'b00,2'b00,2'b11, 0,1,0);
    E_HALT   = mk(0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,1);

    rst_n = 1'b0;
    opcode = OP_R;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("por.state", {28'd0, state}, {28'd0, FETCH});
    chk("por.out", {13'd0, obs}, {13'd0, E_ZERO});
    rst_n = 1'b1;

    // mem_ready=1 latency sweep
    opcode = OP_R;
    cyc("r.f", 1, FETCH, E_FETCH);   cyc("r.d", 1, DECODE, E_DEC);
    cyc("r.x", 1, REXEC, E_REX);     cyc("r.w", 1, RWB, E_RWB);
    opcode = OP_LW;
    cyc("lw.f", 1, FETCH, E_FETCH);  cyc("lw.d", 1, DECODE, E_DEC);
    cyc("lw.a", 1, MEMADR, E_MADR);  cyc("lw.m", 1, MEMRD, E_MRD);
    cyc("lw.w", 1, MEMWB, E_MWB);
    opcode = OP_SW;
    cyc("sw.f", 1, FETCH, E_FETCH);  cyc("sw.d", 1, DECODE, E_DEC);
    cyc("sw.a", 1, MEMADR, E_MADR);  cyc("sw.m", 1, MEMWR, E_MWR);
    opcode = OP_BEQ;
    cyc("beq.f", 1, FETCH, E_FETCH); cyc("beq.d", 0, DECODE, E_DEC);
    cyc("beq.x", 0, BEQ, E_BEQ);
    opcode = OP_J;
    cyc("j.f", 1, FETCH, E_FETCH);   cyc("j.d", 1, DECODE, E_DEC);
    cyc("j.x", 1, JMP, E_JMP);
    opcode = OP_ADDI;
    cyc("ai.f", 1, FETCH, E_FETCH);  cyc("ai.d", 1, DECODE, E_DEC);
    cyc("ai.x", 0, ADDIEX, E_AEX);   cyc("ai.w", 1, ADDIWB, E_AWB);

    // LW with 2 fetch stalls and 3 read stalls: 10 cycles
    opcode = OP_LW;
    cyc("lws.f0", 0, FETCH, E_FSTALL); cyc("lws.f1", 0, FETCH, E_FSTALL);
    cyc("lws.f2", 1, FETCH, E_FETCH);  cyc("lws.d", 1, DECODE, E_DEC);
    cyc("lws.a", 0, MEMADR, E_MADR);
    cyc("lws.m0", 0, MEMRD, E_MRD);    cyc("lws.m1", 0, MEMRD, E_MRD);
    cyc("lws.m2", 0, MEMRD, E_MRD);    cyc("lws.m3", 1, MEMRD, E_MRD);
    cyc("lws.w", 1, MEMWB, E_MWB);

    // SW with one write stall
    opcode = OP_SW;
    cyc("sws.f", 1, FETCH, E_FETCH);   cyc("sws.d", 1, DECODE, E_DEC);
    cyc("sws.a", 1, MEMADR, E_MADR);
    cyc("sws.m0", 0, MEMWR, E_MWRST);  cyc("sws.m1", 1, MEMWR, E_MWR);

    // Illegal opcode trap
    opcode = 6'b010101;
    cyc("ill.f", 1, FETCH, E_FETCH);   cyc("ill.d", 1, DECODE, E_DEC);
    cyc("ill.t", 1, TRAP, E_TRAP);

    // Reset mid-REXEC, held for 3 edges
    opcode = OP_R;
    cyc("rr.f", 1, FETCH, E_FETCH);    cyc("rr.d", 1, DECODE, E_DEC);
    rst_n = 1'b0;
    #1;
    chk("rr.x.state", {28'd0, state}, {28'd0, REXEC});
    chk("rr.x.out", {13'd0, obs}, {13'd0, E_ZERO});
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rr.hold.state", {28'd0, state}, {28'd0, FETCH});
      chk("rr.hold.out", {13'd0, obs}, {13'd0, E_ZERO});
      if (i < 2) begin
        @(posedge clk);
        #1;
      end
    end
    rst_n = 1'b1;
    cyc("rr.f2", 1, FETCH, E_FETCH);   cyc("rr.d2", 1, DECODE, E_DEC);
    cyc("rr.x2", 1, REXEC, E_REX);     cyc("rr.w2", 1, RWB, E_RWB);

    // HALT holds until reset
    opcode = OP_HALT;
    cyc("h.f", 1, FETCH, E_FETCH);     cyc("h.d", 1, DECODE, E_DEC);
    for (int i = 0; i < 20; i++) begin
      opcode = (i % 2 == 0) ? OP_R : OP_LW;
      cyc("h.hold", 1'(i % 2), HALT, E_HALT);
    end
    rst_n = 1'b0;
    #1;
    chk("h.rst.out", {13'd0, obs}, {13'd0, E_ZERO});
    @(posedge clk);
    #1;
    chk("h.rst.state", {28'd0, state}, {28'd0, FETCH});
    rst_n = 1'b1;
    opcode = OP_J;
    cyc("h.f2", 1, FETCH, E_FETCH);    cyc("h.d2", 1, DECODE, E_DEC);
    cyc("h.j2", 1, JMP, E_JMP);
    cyc("h.f3", 0, FETCH, E_FSTALL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
